// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types for the RV32I pipeline hazard sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_DWAIT = 2'd1,
        HZ_RWAIT = 2'd2
    } hzd_state_t;

    localparam int unsigned HZ_CNT_W_DEFAULT = 32;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_cnt
// Description : Wrapping event counter with increment and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = HZ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush sequencer producing per-stage load/NOP controls.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = HZ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    output logic             ld_pc,
    output logic             ld_if_id,
    output logic             ld_id_ex,
    output logic             ld_ex_mem,
    output logic             ld_mem_wb,
    output logic             nop_if_id,
    output logic             nop_id_ex,
    output logic             nop_ex_mem,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hzd_state_t state_q;
    hzd_state_t state_d;
    logic       w_frozen;
    logic       w_flush_inc;
    logic       w_stall_inc;

    assign w_frozen = dcache_req & ~dcache_resp;

    // Priority: D-miss freeze, redirect, load-use, I-miss.
    always_comb begin
        ld_pc       = 1'b1;
        ld_if_id    = 1'b1;
        ld_id_ex    = 1'b1;
        ld_ex_mem   = 1'b1;
        ld_mem_wb   = 1'b1;
        nop_if_id   = 1'b0;
        nop_id_ex   = 1'b0;
        nop_ex_mem  = 1'b0;
        w_flush_inc = 1'b0;
        state_d     = HZ_RUN;
        if (rst) begin
            ld_pc     = 1'b0;
            ld_if_id  = 1'b0;
            ld_id_ex  = 1'b0;
            ld_ex_mem = 1'b0;
            ld_mem_wb = 1'b0;
        end else if (w_frozen) begin
            ld_pc     = 1'b0;
            ld_if_id  = 1'b0;
            ld_id_ex  = 1'b0;
            ld_ex_mem = 1'b0;
            ld_mem_wb = 1'b0;
            state_d   = HZ_DWAIT;
        end else if (br_taken) begin
            if (icache_resp) begin
                nop_if_id   = 1'b1;
                nop_id_ex   = 1'b1;
                w_flush_inc = 1'b1;
            end else begin
                // Hold the fetch address steady until the outstanding fetch lands.
                ld_pc      = 1'b0;
                ld_if_id   = 1'b0;
                ld_id_ex   = 1'b0;
                nop_ex_mem = 1'b1;
                state_d    = HZ_RWAIT;
            end
        end else if (load_use) begin
            ld_pc     = 1'b0;
            ld_if_id  = 1'b0;
            nop_id_ex = 1'b1;
        end else if (!icache_resp) begin
            ld_pc     = 1'b0;
            nop_if_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o     = state_q;
    assign w_stall_inc = ~rst & ~ld_pc;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (w_stall_inc),
        .cnt (stall_cnt)
    );

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (w_flush_inc),
        .cnt (flush_cnt)
    );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl driven by directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic             chk_regs;
        logic [4:0]       ld;
        logic [2:0]       nop;
        logic [1:0]       st;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             load_use;
    logic             br_taken;
    logic             icache_resp;
    logic             dcache_req;
    logic             dcache_resp;
    logic             ld_pc;
    logic             ld_if_id;
    logic             ld_id_ex;
    logic             ld_ex_mem;
    logic             ld_mem_wb;
    logic             nop_if_id;
    logic             nop_id_ex;
    logic             nop_ex_mem;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    exp_t exp_q[$];
    int   n_total;
    int   n_pass;

    hazard_ctrl #(
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_use    (load_use),
        .br_taken    (br_taken),
        .icache_resp (icache_resp),
        .dcache_req  (dcache_req),
        .dcache_resp (dcache_resp),
        .ld_pc       (ld_pc),
        .ld_if_id    (ld_if_id),
        .ld_id_ex    (ld_id_ex),
        .ld_ex_mem   (ld_ex_mem),
        .ld_mem_wb   (ld_mem_wb),
        .nop_if_id   (nop_if_id),
        .nop_id_ex   (nop_id_ex),
        .nop_ex_mem  (nop_ex_mem),
        .state_o     (state_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (vector %0d pending %0d)",
                     name, act, req, n_total, exp_q.size());
        end
    endtask

    // Monitor: outputs are valid mid-cycle, so compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ld",  CNT_W'({ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb}),
                      CNT_W'(e.ld));
                check("nop", CNT_W'({nop_if_id, nop_id_ex, nop_ex_mem}), CNT_W'(e.nop));
                if (e.chk_regs) begin
                    check("state", CNT_W'(state_o), CNT_W'(e.st));
                    check("stall_cnt", stall_cnt, e.stall);
                    check("flush_cnt", flush_cnt, e.flush);
                end
            end
        end
    end

    task automatic step(input logic r, input logic lu, input logic br, input logic ic,
                        input logic dq, input logic dr, input logic [4:0] ld,
                        input logic [2:0] nop, input logic [1:0] st, input int s,
                        input int f, input logic chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        load_use    = lu;
        br_taken    = br;
        icache_resp = ic;
        dcache_req  = dq;
        dcache_resp = dr;
        e.chk_regs  = chk;
        e.ld        = ld;
        e.nop       = nop;
        e.st        = st;
        e.stall     = CNT_W'(s);
        e.flush     = CNT_W'(f);
        exp_q.push_back(e);
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        load_use    = 1'b0;
        br_taken    = 1'b0;
        icache_resp = 1'b1;
        dcache_req  = 1'b0;
        dcache_resp = 1'b0;

        //   rst lu br ic dq dr  ld        nop     st  stall flush chk
        step(1, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0,  0, 0);
        step(1, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0,  0, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0,  0, 1);
        step(0, 1, 0, 1, 0, 0, 5'b00111, 3'b010, 0, 0,  0, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 1,  0, 1);
        step(0, 0, 0, 1, 1, 0, 5'b00000, 3'b000, 0, 1,  0, 1);
        step(0, 0, 0, 1, 1, 0, 5'b00000, 3'b000, 1, 2,  0, 1);
        step(0, 0, 0, 1, 1, 0, 5'b00000, 3'b000, 1, 3,  0, 1);
        step(0, 0, 0, 1, 1, 1, 5'b11111, 3'b000, 1, 4,  0, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 4,  0, 1);
        step(0, 1, 1, 1, 0, 0, 5'b11111, 3'b110, 0, 4,  0, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 4,  1, 1);
        step(0, 0, 1, 0, 0, 0, 5'b00011, 3'b001, 0, 4,  1, 1);
        step(0, 0, 1, 0, 0, 0, 5'b00011, 3'b001, 2, 5,  1, 1);
        step(0, 0, 1, 1, 0, 0, 5'b11111, 3'b110, 2, 6,  1, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 6,  2, 1);
        step(0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0, 6,  2, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 7,  2, 1);
        step(0, 1, 1, 1, 1, 0, 5'b00000, 3'b000, 0, 7,  2, 1);
        step(0, 0, 0, 0, 1, 0, 5'b00000, 3'b000, 1, 8,  2, 1);
        step(0, 0, 0, 1, 1, 0, 5'b00000, 3'b000, 1, 9,  2, 1);
        step(0, 0, 0, 1, 1, 0, 5'b00000, 3'b000, 1, 10, 2, 1);
        step(1, 0, 1, 1, 1, 0, 5'b00000, 3'b000, 1, 11, 2, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 0,  0, 1);
        step(0, 1, 0, 0, 0, 0, 5'b00111, 3'b010, 0, 0,  0, 1);
        step(0, 0, 0, 1, 0, 0, 5'b11111, 3'b000, 0, 1,  0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
